// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - shared types, segment constants and polarity helper for the scan controller
package seg7_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    GUARD = 2'd2
  } state_t;

  // Active-high {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_0   = 7'b0111111;
  localparam logic [6:0] SEG_1   = 7'b0000110;
  localparam logic [6:0] SEG_2   = 7'b1011011;
  localparam logic [6:0] SEG_3   = 7'b1001111;
  localparam logic [6:0] SEG_4   = 7'b1100110;
  localparam logic [6:0] SEG_5   = 7'b1101101;
  localparam logic [6:0] SEG_6   = 7'b1111101;
  localparam logic [6:0] SEG_7   = 7'b0000111;
  localparam logic [6:0] SEG_8   = 7'b1111111;
  localparam logic [6:0] SEG_9   = 7'b1101111;
  localparam logic [6:0] SEG_OFF = 7'b0000000;

  function automatic logic [6:0] seg_polarity(input logic [6:0] seg, input logic active_low);
    return active_low ? ~seg : seg;
  endfunction

endpackage

// File: rtl/seg7_scan_ctrl_if.sv
// rtl/seg7_scan_ctrl_if.sv - datapath-side controls and display-pin outputs of the scan controller
interface seg7_scan_ctrl_if #(
  parameter int NUM_DIGITS = 4
);
  logic                      en;
  logic                      load;
  logic [4*NUM_DIGITS-1:0]   bcd_in;
  logic                      blank_lz;
  logic [6:0]                seg;
  logic [NUM_DIGITS-1:0]     an;
  logic                      frame_done;

  modport master (
    output en, load, bcd_in, blank_lz,
    input  seg, an, frame_done
  );

  modport slave (
    input  en, load, bcd_in, blank_lz,
    output seg, an, frame_done
  );
endinterface

// File: rtl/seg7_scan_ctrl_bcd_to_seg.sv
// rtl/seg7_scan_ctrl_bcd_to_seg.sv - combinational BCD to active-high 7-segment decoder
module bcd_to_seg
  import seg7_pkg::*;
(
  input  logic [3:0] i_bcd,
  output logic [6:0] o_seg
);

  always_comb begin
    o_seg = SEG_OFF;
    case (i_bcd)
      4'd0:    o_seg = SEG_0;
      4'd1:    o_seg = SEG_1;
      4'd2:    o_seg = SEG_2;
      4'd3:    o_seg = SEG_3;
      4'd4:    o_seg = SEG_4;
      4'd5:    o_seg = SEG_5;
      4'd6:    o_seg = SEG_6;
      4'd7:    o_seg = SEG_7;
      4'd8:    o_seg = SEG_8;
      4'd9:    o_seg = SEG_9;
      default: o_seg = SEG_OFF;
    endcase
  end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// rtl/seg7_scan_ctrl.sv - multiplexed BCD 7-segment scan controller with dead-time guard and frame-atomic updates
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int DIGIT_CYCLES = 1000,
  parameter int GUARD_CYCLES = 16,
  parameter bit COMMON_ANODE = 1'b1
) (
  input logic            clk,
  input logic            rst,
  seg7_scan_ctrl_if.slave bus
);

  localparam int MAXC = (DIGIT_CYCLES > GUARD_CYCLES) ? DIGIT_CYCLES : GUARD_CYCLES;
  localparam int PW   = (MAXC > 1) ? $clog2(MAXC) : 1;
  localparam int IW   = $clog2(NUM_DIGITS);
  localparam int BW   = 4 * NUM_DIGITS;

  localparam logic [PW-1:0]         DRV_LAST = PW'(DIGIT_CYCLES - 1);
  localparam logic [PW-1:0]         GRD_LAST = PW'(GUARD_CYCLES - 1);
  localparam logic [IW-1:0]         IDX_LAST = IW'(NUM_DIGITS - 1);
  localparam logic [6:0]            SEG_IDLE = COMMON_ANODE ? 7'h7F : 7'h00;
  localparam logic [NUM_DIGITS-1:0] AN_IDLE  = COMMON_ANODE ? {NUM_DIGITS{1'b1}} : {NUM_DIGITS{1'b0}};

  state_t                r_state;
  logic [PW-1:0]         r_cnt;
  logic [IW-1:0]         r_idx;
  logic [BW-1:0]         r_pending;
  logic                  r_pend_valid;
  logic [BW-1:0]         r_active;
  logic [6:0]            r_seg;
  logic [NUM_DIGITS-1:0] r_an;
  logic                  r_frame_done;

  state_t                w_state_nxt;
  logic [PW-1:0]         w_cnt_nxt;
  logic [IW-1:0]         w_idx_nxt;
  logic                  w_boundary;
  logic                  w_frame_nxt;
  logic [BW-1:0]         w_active_nxt;
  logic [3:0]            w_digit;
  logic [6:0]            w_dec;
  logic                  w_zero_run;
  logic                  w_blank;
  logic [NUM_DIGITS-1:0] w_an_on;
  logic [6:0]            w_seg_nxt;
  logic [NUM_DIGITS-1:0] w_an_nxt;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_idx_nxt   = r_idx;
    w_boundary  = 1'b0;
    w_frame_nxt = 1'b0;
    if (!bus.en) begin
      w_state_nxt = IDLE;
      w_cnt_nxt   = '0;
      w_idx_nxt   = '0;
    end else begin
      case (r_state)
        IDLE: begin
          w_state_nxt = DRIVE;
          w_cnt_nxt   = '0;
          w_idx_nxt   = '0;
          w_boundary  = 1'b1;
        end
        DRIVE: begin
          if (r_cnt == DRV_LAST) begin
            w_state_nxt = GUARD;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = r_cnt + PW'(1);
          end
        end
        GUARD: begin
          if (r_cnt == GRD_LAST) begin
            w_state_nxt = DRIVE;
            w_cnt_nxt   = '0;
            if (r_idx == IDX_LAST) begin
              w_idx_nxt   = '0;
              w_boundary  = 1'b1;
              w_frame_nxt = 1'b1;
            end else begin
              w_idx_nxt = r_idx + IW'(1);
            end
          end else begin
            w_cnt_nxt = r_cnt + PW'(1);
          end
        end
        default: begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
          w_idx_nxt   = '0;
        end
      endcase
    end
  end

  // Decode from the value that will be active after this edge so the boundary digit is never stale.
  always_comb begin
    w_active_nxt = r_active;
    if (w_boundary) begin
      if (bus.load)          w_active_nxt = bus.bcd_in;
      else if (r_pend_valid) w_active_nxt = r_pending;
    end
  end

  always_comb begin
    w_digit    = 4'h0;
    w_zero_run = 1'b1;
    w_blank    = 1'b0;
    w_an_on    = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      w_an_on[i] = (w_idx_nxt == IW'(i));
      if (w_idx_nxt == IW'(i)) w_digit = w_active_nxt[4*i +: 4];
    end
    // Walk down from the most significant digit; digit 0 is deliberately excluded.
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      w_zero_run = w_zero_run && (w_active_nxt[4*i +: 4] == 4'h0);
      if (w_idx_nxt == IW'(i)) w_blank = bus.blank_lz && w_zero_run;
    end
  end

  bcd_to_seg u_dec (
    .i_bcd (w_digit),
    .o_seg (w_dec)
  );

  always_comb begin
    w_seg_nxt = SEG_IDLE;
    w_an_nxt  = AN_IDLE;
    if (w_state_nxt == DRIVE) begin
      w_seg_nxt = seg_polarity(w_blank ? SEG_OFF : w_dec, COMMON_ANODE);
      w_an_nxt  = COMMON_ANODE ? ~w_an_on : w_an_on;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_idx        <= '0;
      r_pending    <= '0;
      r_pend_valid <= 1'b0;
      r_active     <= '0;
      r_seg        <= SEG_IDLE;
      r_an         <= AN_IDLE;
      r_frame_done <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_idx        <= w_idx_nxt;
      r_active     <= w_active_nxt;
      r_seg        <= w_seg_nxt;
      r_an         <= w_an_nxt;
      r_frame_done <= w_frame_nxt;
      if (bus.load) r_pending <= bus.bcd_in;
      if (w_boundary)    r_pend_valid <= 1'b0;
      else if (bus.load) r_pend_valid <= 1'b1;
    end
  end

  assign bus.seg        = r_seg;
  assign bus.an         = r_an;
  assign bus.frame_done = r_frame_done;

endmodule
